ahb_master_driver: RTL and testbench

AHB_MASTER_DRIVER -- requirements
Module: ahb_master_driver

---
 rtl/ahb_master_driver_if.sv | 23 ++
 rtl/ahb_master_driver.sv | 152 +++++++++++++++
 tb/tb_ahb_master_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_driver_if.sv
// AHB-Lite bus signals between ahb_master_driver and a single slave.
// The master drives the address/control/write-data side; the slave returns ready, response and read data.
interface ahb_master_driver_if;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_master_driver.sv
// AHB-Lite master: turns one command into a SINGLE or INCR4 transfer with pipelined address/data phases.
// Define AHB_MASTER_BURST_EN to honour cmd_burst (INCR4); otherwise every command is one SINGLE beat.
module ahb_master_driver (
  input  logic                Hclk,
  input  logic                Hresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [31:0]         cmd_addr,
  input  logic                cmd_burst,
  input  logic [31:0]         cmd_wdata,
  output logic                wdata_take,
  output logic                rd_valid,
  output logic [31:0]         rd_data,
  output logic                done,
  output logic                err,
  ahb_master_driver_if.master ahb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_DATA,
    S_DATA,
    S_ERR
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  state_t      r_state;
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [2:0]  r_hburst;
  logic [31:0] r_hwdata;
  logic [1:0]  r_beats_left;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;
  logic        r_done;
  logic        r_err;

  logic w_burst;
  logic w_data_phase;
  logic w_addr_done;
  logic w_data_ok;
  logic w_data_err;

`ifdef AHB_MASTER_BURST_EN
  assign w_burst = cmd_burst;
`else
  logic w_unused_burst;
  assign w_burst        = 1'b0;
  assign w_unused_burst = cmd_burst;
`endif

  always_comb begin
    w_data_phase = (r_state == S_ADDR_DATA) || (r_state == S_DATA);
    w_addr_done  = ((r_state == S_ADDR) || (r_state == S_ADDR_DATA)) && ahb.Hreadyout;
    w_data_ok    = w_data_phase && ahb.Hreadyout && (ahb.Hresp == RESP_OKAY);
    w_data_err   = w_data_phase && !ahb.Hreadyout && (ahb.Hresp == RESP_ERR);
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state      <= S_IDLE;
      r_haddr      <= '0;
      r_htrans     <= TR_IDLE;
      r_hwrite     <= 1'b0;
      r_hburst     <= '0;
      r_hwdata     <= '0;
      r_beats_left <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_data_ok && !r_hwrite) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= ahb.Hrdata;
      end
      if (w_addr_done && r_hwrite)
        r_hwdata <= cmd_wdata;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_haddr      <= cmd_addr;
            r_htrans     <= TR_NONSEQ;
            r_hwrite     <= cmd_write;
            r_hburst     <= w_burst ? 3'b011 : 3'b000;
            r_beats_left <= w_burst ? 2'd3 : 2'd0;
            r_state      <= S_ADDR;
          end
        end
        // ADDR has no data phase in flight, so only ADDR_DATA can see an ERROR here.
        S_ADDR, S_ADDR_DATA: begin
          if (w_data_err) begin
            r_htrans <= TR_IDLE;
            r_state  <= S_ERR;
          end else if (ahb.Hreadyout) begin
            if (r_beats_left != 2'd0) begin
              r_haddr      <= r_haddr + 32'd4;
              r_htrans     <= TR_SEQ;
              r_beats_left <= r_beats_left - 2'd1;
              r_state      <= S_ADDR_DATA;
            end else begin
              r_htrans <= TR_IDLE;
              r_state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_data_err) begin
            r_state <= S_ERR;
          end else if (ahb.Hreadyout) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          if (ahb.Hreadyout) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign wdata_take = w_addr_done && r_hwrite;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign done       = r_done;
  assign err        = r_err;

  assign ahb.Haddr  = r_haddr;
  assign ahb.Htrans = r_htrans;
  assign ahb.Hwrite = r_hwrite;
  assign ahb.Hsize  = 3'b010;
  assign ahb.Hburst = r_hburst;
  assign ahb.Hwdata = r_hwdata;

endmodule

// File: tb/tb_ahb_master_driver.sv
// Directed per-cycle vector bench for ahb_master_driver, plus a mid-transfer reset sequence.
// INCR4 vectors are added when AHB_MASTER_BURST_EN is defined.
module tb_ahb_master_driver;

  typedef struct {
    logic        v, w, b;
    logic [31:0] a, wd;
    logic        rdy;
    logic [1:0]  rsp;
    logic [31:0] rd;
  } in_t;

  typedef struct {
    logic [1:0]  tr;
    logic [31:0] ad, hw;
    logic [2:0]  hb;
    logic        tk, rv;
    logic [31:0] rdd;
    logic        dn, er, cr;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

`ifdef AHB_MASTER_BURST_EN
  localparam int unsigned IGN_B    = 0;
  localparam int          RST_WAIT = 3;
  localparam logic [1:0]  PRE_TR   = 2'b11;
  localparam logic [31:0] PRE_AD   = 32'h8000_0078;
`else
  localparam int unsigned IGN_B    = 1;
  localparam int          RST_WAIT = 1;
  localparam logic [1:0]  PRE_TR   = 2'b10;
  localparam logic [31:0] PRE_AD   = 32'h8000_0070;
`endif

  logic        Hclk, Hresetn;
  logic        cmd_valid, cmd_write, cmd_burst;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_ready, wdata_take, rd_valid, done, err;
  logic [31:0] rd_data;

  ahb_master_driver_if ahb ();

  ahb_master_driver dut (
    .Hclk       (Hclk),
    .Hresetn    (Hresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_burst  (cmd_burst),
    .cmd_wdata  (cmd_wdata),
    .wdata_take (wdata_take),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .done       (done),
    .err        (err),
    .ahb        (ahb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic in_t si(input int unsigned v, w, b, a, wd, rdy, rsp, rd);
    in_t x;
    x.v = v[0]; x.w = w[0]; x.b = b[0]; x.a = a; x.wd = wd;
    x.rdy = rdy[0]; x.rsp = rsp[1:0]; x.rd = rd;
    return x;
  endfunction

  function automatic ex_t se(input int unsigned tr, ad, hw, hb, tk, rv, rdd, dn, er, cr);
    ex_t x;
    x.tr = tr[1:0]; x.ad = ad; x.hw = hw; x.hb = hb[2:0]; x.tk = tk[0];
    x.rv = rv[0]; x.rdd = rdd; x.dn = dn[0]; x.er = er[0]; x.cr = cr[0];
    return x;
  endfunction

  function automatic void add(input in_t i, input ex_t e);
    vec_t x;
    x.i = i;
    x.e = e;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    cmd_valid     = x.v;
    cmd_write     = x.w;
    cmd_burst     = x.b;
    cmd_addr      = x.a;
    cmd_wdata     = x.wd;
    ahb.Hreadyout = x.rdy;
    ahb.Hresp     = x.rsp;
    ahb.Hrdata    = x.rd;
  endtask

  task automatic check_vec(input int k, input ex_t e);
    chk("htrans",     k, 32'(ahb.Htrans), 32'(e.tr));
    chk("haddr",      k, ahb.Haddr,       e.ad);
    chk("hwdata",     k, ahb.Hwdata,      e.hw);
    chk("hburst",     k, 32'(ahb.Hburst), 32'(e.hb));
    chk("wdata_take", k, 32'(wdata_take), 32'(e.tk));
    chk("rd_valid",   k, 32'(rd_valid),   32'(e.rv));
    chk("rd_data",    k, rd_data,         e.rdd);
    chk("done",       k, 32'(done),       32'(e.dn));
    chk("err",        k, 32'(err),        32'(e.er));
    chk("cmd_ready",  k, 32'(cmd_ready),  32'(e.cr));
  endtask

  initial begin
    // Single write, single read, read with 3 wait states, read error, back-to-back writes.
    add(si(1,1,0,'h80000000,'hDEADBEEF,1,0,0), se(0,'h00000000,'h00000000,0,0,0,'h00000000,0,0,1));
    add(si(0,1,0,0,'hDEADBEEF,1,0,0),          se(2,'h80000000,'h00000000,0,1,0,'h00000000,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000000,'hDEADBEEF,0,0,0,'h00000000,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000000,'hDEADBEEF,0,0,0,'h00000000,1,0,1));
    add(si(1,0,0,'h80000004,0,1,0,0),          se(0,'h80000000,'hDEADBEEF,0,0,0,'h00000000,0,0,1));
    add(si(0,0,0,0,0,1,0,0),                   se(2,'h80000004,'hDEADBEEF,0,0,0,'h00000000,0,0,0));
    add(si(0,0,0,0,0,1,0,'hCAFEBABE),          se(0,'h80000004,'hDEADBEEF,0,0,0,'h00000000,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000004,'hDEADBEEF,0,0,1,'hCAFEBABE,1,0,1));
    add(si(1,0,IGN_B,'h80000020,0,1,0,0),      se(0,'h80000004,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,1));
    add(si(0,0,0,0,0,1,0,0),                   se(2,'h80000020,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,0));
    add(si(0,0,0,0,0,0,0,'h11111111),          se(0,'h80000020,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,0));
    add(si(0,0,0,0,0,0,0,'h11111111),          se(0,'h80000020,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,0));
    add(si(0,0,0,0,0,0,0,'h11111111),          se(0,'h80000020,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,0));
    add(si(0,0,0,0,0,1,0,'h12345678),          se(0,'h80000020,'hDEADBEEF,0,0,0,'hCAFEBABE,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000020,'hDEADBEEF,0,0,1,'h12345678,1,0,1));
    add(si(1,0,0,'h80000030,0,1,0,0),          se(0,'h80000020,'hDEADBEEF,0,0,0,'h12345678,0,0,1));
    add(si(0,0,0,0,0,1,0,0),                   se(2,'h80000030,'hDEADBEEF,0,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,0,1,'hBAD0BAD0),          se(0,'h80000030,'hDEADBEEF,0,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,1,'hBAD0BAD0),          se(0,'h80000030,'hDEADBEEF,0,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000030,'hDEADBEEF,0,0,0,'h12345678,1,1,1));
    add(si(1,1,0,'h80000040,'h11223344,1,0,0), se(0,'h80000030,'hDEADBEEF,0,0,0,'h12345678,0,0,1));
    add(si(1,1,0,'h80000040,'h11223344,1,0,0), se(2,'h80000040,'hDEADBEEF,0,1,0,'h12345678,0,0,0));
    add(si(1,1,0,'h80000040,'h11223344,1,0,0), se(0,'h80000040,'h11223344,0,0,0,'h12345678,0,0,0));
    add(si(1,1,0,'h80000040,'h11223344,1,0,0), se(0,'h80000040,'h11223344,0,0,0,'h12345678,1,0,1));
    add(si(0,1,0,0,'h99AABBCC,0,0,0),          se(2,'h80000040,'h11223344,0,0,0,'h12345678,0,0,0));
    add(si(0,1,0,0,'h99AABBCC,1,0,0),          se(2,'h80000040,'h11223344,0,1,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000040,'h99AABBCC,0,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000040,'h99AABBCC,0,0,0,'h12345678,1,0,1));
`ifdef AHB_MASTER_BURST_EN
    // INCR4 write, INCR4 read with 3 waits on beat 2, INCR4 read with ERROR on beat 2.
    add(si(1,1,1,'h80000010,'hB0000000,1,0,0), se(0,'h80000040,'h99AABBCC,0,0,0,'h12345678,0,0,1));
    add(si(0,1,0,0,'hB0000000,1,0,0),          se(2,'h80000010,'h99AABBCC,3,1,0,'h12345678,0,0,0));
    add(si(0,1,0,0,'hB0000001,1,0,0),          se(3,'h80000014,'hB0000000,3,1,0,'h12345678,0,0,0));
    add(si(0,1,0,0,'hB0000002,1,0,0),          se(3,'h80000018,'hB0000001,3,1,0,'h12345678,0,0,0));
    add(si(0,1,0,0,'hB0000003,1,0,0),          se(3,'h8000001C,'hB0000002,3,1,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h8000001C,'hB0000003,3,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h8000001C,'hB0000003,3,0,0,'h12345678,1,0,1));
    add(si(1,0,1,'h80000050,0,1,0,0),          se(0,'h8000001C,'hB0000003,3,0,0,'h12345678,0,0,1));
    add(si(0,0,0,0,0,1,0,0),                   se(2,'h80000050,'hB0000003,3,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,1,0,'hC0000001),          se(3,'h80000054,'hB0000003,3,0,0,'h12345678,0,0,0));
    add(si(0,0,0,0,0,0,0,0),                   se(3,'h80000058,'hB0000003,3,0,1,'hC0000001,0,0,0));
    add(si(0,0,0,0,0,0,0,0),                   se(3,'h80000058,'hB0000003,3,0,0,'hC0000001,0,0,0));
    add(si(0,0,0,0,0,0,0,0),                   se(3,'h80000058,'hB0000003,3,0,0,'hC0000001,0,0,0));
    add(si(0,0,0,0,0,1,0,'hC0000002),          se(3,'h80000058,'hB0000003,3,0,0,'hC0000001,0,0,0));
    add(si(0,0,0,0,0,1,0,'hC0000003),          se(3,'h8000005C,'hB0000003,3,0,1,'hC0000002,0,0,0));
    add(si(0,0,0,0,0,1,0,'hC0000004),          se(0,'h8000005C,'hB0000003,3,0,1,'hC0000003,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h8000005C,'hB0000003,3,0,1,'hC0000004,1,0,1));
    add(si(1,0,1,'h80000060,0,1,0,0),          se(0,'h8000005C,'hB0000003,3,0,0,'hC0000004,0,0,1));
    add(si(0,0,0,0,0,1,0,0),                   se(2,'h80000060,'hB0000003,3,0,0,'hC0000004,0,0,0));
    add(si(0,0,0,0,0,1,0,'hD0000001),          se(3,'h80000064,'hB0000003,3,0,0,'hC0000004,0,0,0));
    add(si(0,0,0,0,0,0,1,0),                   se(3,'h80000068,'hB0000003,3,0,1,'hD0000001,0,0,0));
    add(si(0,0,0,0,0,1,1,0),                   se(0,'h80000068,'hB0000003,3,0,0,'hD0000001,0,0,0));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000068,'hB0000003,3,0,0,'hD0000001,1,1,1));
    add(si(0,0,0,0,0,1,0,0),                   se(0,'h80000068,'hB0000003,3,0,0,'hD0000001,0,0,1));
`endif

    // cmd_valid is already high during reset: it must not be accepted before release.
    Hresetn = 1'b0;
    drive(vecs[0].i);
    #12;
    chk("rst_haddr",      0, ahb.Haddr,          32'h0);
    chk("rst_htrans",     0, 32'(ahb.Htrans),    32'h0);
    chk("rst_hwrite",     0, 32'(ahb.Hwrite),    32'h0);
    chk("rst_hsize",      0, 32'(ahb.Hsize),     32'h2);
    chk("rst_hburst",     0, 32'(ahb.Hburst),    32'h0);
    chk("rst_hwdata",     0, ahb.Hwdata,         32'h0);
    chk("rst_cmd_ready",  0, 32'(cmd_ready),     32'h1);
    chk("rst_wdata_take", 0, 32'(wdata_take),    32'h0);
    chk("rst_rd_valid",   0, 32'(rd_valid),      32'h0);
    chk("rst_rd_data",    0, rd_data,            32'h0);
    chk("rst_done",       0, 32'(done),          32'h0);
    chk("rst_err",        0, 32'(err),           32'h0);
    @(posedge Hclk);
    #1;
    Hresetn = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].i);
      @(negedge Hclk);
      check_vec(k, vecs[k].e);
      @(posedge Hclk);
      #1;
    end

    // Asynchronous reset in the middle of a read transfer.
    drive(si(1,0,1,'h80000070,0,1,0,0));
    @(posedge Hclk);
    #1;
    cmd_valid = 1'b0;
    repeat (RST_WAIT - 1) begin
      @(posedge Hclk);
      #1;
    end
    #1;
    chk("mid_htrans_pre", 0, 32'(ahb.Htrans), 32'(PRE_TR));
    chk("mid_haddr_pre",  0, ahb.Haddr,       PRE_AD);
    Hresetn = 1'b0;
    #1;
    chk("mid_htrans_rst", 0, 32'(ahb.Htrans), 32'h0);
    chk("mid_ready_rst",  0, 32'(cmd_ready),  32'h1);
    chk("mid_haddr_rst",  0, ahb.Haddr,       32'h0);
    repeat (2) @(posedge Hclk);
    #1;
    Hresetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Hclk);
      chk("mid_done", c, 32'(done),       32'h0);
      chk("mid_err",  c, 32'(err),        32'h0);
      chk("mid_idle", c, 32'(ahb.Htrans), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
